// File: rtl/cu_seq_if.sv
// Bus bundle for cu_seq: instruction-memory req/ack fetch port and the
// register-bank port (index select, write strobe/data, combinational reads).
interface cu_seq_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic          imem_req_out;
  logic [AW-1:0] imem_addr_out;
  logic          imem_ack_in;
  logic [DW-1:0] imem_data_in;
  logic [11:0]   rs_out;
  logic          rw_out;
  logic [DW-1:0] d_out;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;

  // Sequencer side
  modport master (
    output imem_req_out, imem_addr_out, rs_out, rw_out, d_out,
    input  imem_ack_in, imem_data_in, a_in, b_in
  );

  // Memory / register-bank side
  modport slave (
    input  imem_req_out, imem_addr_out, rs_out, rw_out, d_out,
    output imem_ack_in, imem_data_in, a_in, b_in
  );
endinterface

// File: rtl/cu_seq.sv
// cu_seq: multi-cycle control sequencer for mycpu.
// IDLE -> FETCH -> DECODE -> EXEC -> (WB) -> FETCH, HALT on opcode F.
// Optional feature macro: MYCPU_TRAP_EN (illegal instruction halts with
// trap_out=1). Without it, illegal instructions execute as NOP.
module cu_seq #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 8,
  parameter int unsigned NREGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  output logic       busy_out,
  output logic       halted_out,
  output logic       zf_out,
  output logic       cf_out,
  output logic       trap_out,
  cu_seq_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] res_q;
  logic          zf_q;
  logic          cf_q;
  logic          req_q;
  logic          rw_q;
  logic          busy_q;
  logic          halted_q;
`ifdef MYCPU_TRAP_EN
  logic          trap_q;
`endif

  // Decode / ALU results for the instruction held in IR
  logic [3:0]    op;
  logic [3:0]    rd_idx;
  logic [3:0]    ra_idx;
  logic [3:0]    rb_idx;
  logic [DW-1:0] alu_res;
  logic          alu_cf;
  logic          wr_op;
  logic          use_a;
  logic          use_b;
  logic          upd_zf;
  logic          upd_cf;
  logic          bad_op;
  logic          halt_op;
  logic          illegal;

  function automatic logic idx_bad(input logic [3:0] idx);
    return 32'(idx) >= NREGS;
  endfunction

  assign op     = ir_q[15:12];
  assign rd_idx = ir_q[11:8];
  assign ra_idx = ir_q[7:4];
  assign rb_idx = ir_q[3:0];

  // Combinational decode and ALU over the settled register-bank reads
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    wr_op   = 1'b0;
    use_a   = 1'b0;
    use_b   = 1'b0;
    upd_zf  = 1'b0;
    upd_cf  = 1'b0;
    bad_op  = 1'b0;
    halt_op = 1'b0;
    unique case (op)
      4'h0: ;
      4'h1: begin
        {alu_cf, alu_res} = {1'b0, bus.a_in} + {1'b0, bus.b_in};
        wr_op = 1'b1; use_a = 1'b1; use_b = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1;
      end
      4'h2: begin
        {alu_cf, alu_res} = {1'b0, bus.a_in} - {1'b0, bus.b_in};
        wr_op = 1'b1; use_a = 1'b1; use_b = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1;
      end
      4'h3: begin
        alu_res = bus.a_in & bus.b_in;
        wr_op = 1'b1; use_a = 1'b1; use_b = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1;
      end
      4'h4: begin
        alu_res = bus.a_in | bus.b_in;
        wr_op = 1'b1; use_a = 1'b1; use_b = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1;
      end
      4'h5: begin
        alu_res = bus.a_in ^ bus.b_in;
        wr_op = 1'b1; use_a = 1'b1; use_b = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1;
      end
      4'h6: begin
        alu_res = bus.a_in;
        wr_op = 1'b1; use_a = 1'b1;
      end
      4'h7: begin
        alu_res = {{(DW-8){1'b0}}, ir_q[7:0]};
        wr_op = 1'b1;
      end
      4'h8: begin
        alu_res = {bus.a_in[DW-2:0], 1'b0};
        alu_cf  = bus.a_in[DW-1];
        wr_op = 1'b1; use_a = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1;
      end
      4'hF: halt_op = 1'b1;
      default: bad_op = 1'b1;
    endcase
    illegal = bad_op
            | (wr_op & idx_bad(rd_idx))
            | (use_a & idx_bad(ra_idx))
            | (use_b & idx_bad(rb_idx));
  end

  // Sequencer FSM with registered outputs; rw_q is a one-cycle strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      res_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      req_q    <= 1'b0;
      rw_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
`ifdef MYCPU_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      rw_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start_in) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
`ifdef MYCPU_TRAP_EN
            trap_q   <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (bus.imem_ack_in) begin
            ir_q    <= bus.imem_data_in;
            pc_q    <= pc_q + AW'(1);
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (illegal) begin
`ifdef MYCPU_TRAP_EN
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            trap_q   <= 1'b1;
`else
            state_q  <= S_FETCH;
            req_q    <= 1'b1;
`endif
          end else if (halt_op) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (wr_op) begin
            res_q   <= alu_res;
            if (upd_zf) zf_q <= (alu_res == '0);
            if (upd_cf) cf_q <= alu_cf;
            rw_q    <= 1'b1;
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req_out  = req_q;
  assign bus.imem_addr_out = pc_q;
  assign bus.rs_out        = ir_q[11:0];
  assign bus.rw_out        = rw_q;
  assign bus.d_out         = res_q;
  assign busy_out          = busy_q;
  assign halted_out        = halted_q;
  assign zf_out            = zf_q;
  assign cf_out            = cf_q;
`ifdef MYCPU_TRAP_EN
  assign trap_out          = trap_q;
`else
  assign trap_out          = 1'b0;
`endif

endmodule

// File: tb/tb_cu_seq.sv
// Directed testbench for cu_seq: instruction memory and register bank models,
// hand-computed expected writes, flags, fetch addresses and timing.
module tb_cu_seq;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic start_in = 1'b0;
  logic busy_out, halted_out, zf_out, cf_out, trap_out;

  cu_seq_if #(.DW(16), .AW(8)) bus ();

  cu_seq #(.DW(16), .AW(8), .NREGS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .busy_out   (busy_out),
    .halted_out (halted_out),
    .zf_out     (zf_out),
    .cf_out     (cf_out),
    .trap_out   (trap_out),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem  [256];
  logic [15:0] regs [16];
  int   dly0  = 0;
  logic stray = 1'b0;
  int   wcnt  = 0;

  int   errs   = 0;
  int   checks = 0;

  int          w_idx [$];
  logic [15:0] w_dat [$];
  logic        w_zf  [$];
  logic        w_cf  [$];
  int          w_cyc [$];
  int          a_addr[$];
  int          a_cyc [$];
  int          a_held[$];
  int          cyc  = 0;
  int          hold = 0;

  int          e2_idx [8] = '{2, 1, 3, 4, 5, 6, 7, 0};
  logic [15:0] e2_dat [8] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0002,
                              16'hFFFE, 16'hFFFE, 16'h0000, 16'h0002};
  logic        e2_zf  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        e2_cf  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  assign bus.a_in = regs[bus.rs_out[7:4]];
  assign bus.b_in = regs[bus.rs_out[3:0]];

  // Register bank and event logs, sampled on the active edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      w_idx.delete(); w_dat.delete(); w_zf.delete(); w_cf.delete(); w_cyc.delete();
      a_addr.delete(); a_cyc.delete(); a_held.delete();
      hold = 0;
    end else begin
      if (bus.rw_out) begin
        regs[bus.rs_out[11:8]] <= bus.d_out;
        w_idx.push_back(int'(bus.rs_out[11:8]));
        w_dat.push_back(bus.d_out);
        w_zf.push_back(zf_out);
        w_cf.push_back(cf_out);
        w_cyc.push_back(cyc);
      end
      if (bus.imem_req_out) begin
        hold = hold + 1;
        if (bus.imem_ack_in) begin
          a_addr.push_back(int'(bus.imem_addr_out));
          a_cyc.push_back(cyc);
          a_held.push_back(hold);
          hold = 0;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Instruction memory responder; address 0 acks after dly0 wait cycles
  always @(negedge clk) begin
    if (rst) begin
      bus.imem_ack_in  = 1'b0;
      bus.imem_data_in = '0;
      wcnt = 0;
    end else if (!bus.imem_req_out) begin
      bus.imem_ack_in  = stray;
      bus.imem_data_in = 16'h7155;
      wcnt = 0;
    end else if (wcnt >= ((bus.imem_addr_out == 8'h00) ? dly0 : 0)) begin
      bus.imem_ack_in  = 1'b1;
      bus.imem_data_in = mem[bus.imem_addr_out];
    end else begin
      bus.imem_ack_in  = 1'b0;
      wcnt = wcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start_in = 1'b0;
    stray    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, input string tag);
    int n = 0;
    while (!halted_out && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(halted_out), 32'd1);
  endtask

  task automatic wait_acks(input int cnt, input int maxc, input string tag);
    int n = 0;
    while (a_addr.size() < cnt && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(a_addr.size() >= cnt), 32'd1);
  endtask

  task automatic check_write(input string tag, input int i, input int idx, input logic [15:0] dat);
    if (i < w_idx.size()) begin
      check({tag, " idx"}, 32'(w_idx[i]), 32'(idx));
      check({tag, " data"}, 32'(w_dat[i]), 32'(dat));
    end else begin
      check({tag, " missing"}, 32'(w_idx.size()), 32'(i + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ctl"}, 32'({busy_out, halted_out, bus.imem_req_out, bus.rw_out,
                              zf_out, cf_out, trap_out}), 32'd0);
    check({tag, " addr"}, 32'(bus.imem_addr_out), 32'd0);
    check({tag, " rs"}, 32'(bus.rs_out), 32'd0);
    check({tag, " d"}, 32'(bus.d_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // LDI/LDI/ADD/HALT
    clear_mem();
    mem[0] = 16'h7112; mem[1] = 16'h7234; mem[2] = 16'h1312; mem[3] = 16'hF000;
    pulse_start();
    check("t1 busy", 32'(busy_out), 32'd1);
    wait_halt(100, "t1 halt");
    check("t1 nwr", 32'(w_idx.size()), 32'd3);
    check_write("t1 w0", 0, 1, 16'h0012);
    check_write("t1 w1", 1, 2, 16'h0034);
    check_write("t1 w2", 2, 3, 16'h0046);
    check("t1 flags", 32'({zf_out, cf_out}), 32'd0);
    check("t1 busy end", 32'(busy_out), 32'd0);
    // Stray ack while halted must not fetch or write
    stray = 1'b1;
    repeat (5) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray halted", 32'(halted_out), 32'd1);
    check("stray nwr", 32'(w_idx.size()), 32'd3);
    check("stray nack", 32'(a_addr.size()), 32'd4);

    // Arithmetic, logic, shift, move, flags
    do_reset();
    clear_mem();
    mem[0] = 16'h7201; mem[1] = 16'h2102; mem[2] = 16'h1312; mem[3] = 16'h2421;
    mem[4] = 16'h5512; mem[5] = 16'h8610; mem[6] = 16'h3730; mem[7] = 16'h6040;
    mem[8] = 16'h0000; mem[9] = 16'hF000;
    pulse_start();
    wait_halt(200, "t2 halt");
    check("t2 nwr", 32'(w_idx.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_write($sformatf("t2 w%0d", i), i, e2_idx[i], e2_dat[i]);
      if (i < w_zf.size()) begin
        check($sformatf("t2 w%0d zf", i), 32'(w_zf[i]), 32'(e2_zf[i]));
        check($sformatf("t2 w%0d cf", i), 32'(w_cf[i]), 32'(e2_cf[i]));
      end
    end
    check("t2 final flags", 32'({zf_out, cf_out}), 32'b10);

    // Delayed ack on first fetch, immediate ack afterwards; WB timing
    do_reset();
    clear_mem();
    dly0 = 3;
    mem[0] = 16'h7112; mem[1] = 16'h7234; mem[2] = 16'hF000;
    pulse_start();
    wait_halt(100, "t3 halt");
    dly0 = 0;
    if (a_held.size() >= 2 && w_cyc.size() >= 2) begin
      check("t3 held0", 32'(a_held[0]), 32'd4);
      check("t3 held1", 32'(a_held[1]), 32'd1);
      check("t3 wb lat0", 32'(w_cyc[0] - a_cyc[0]), 32'd3);
      check("t3 wb lat1", 32'(w_cyc[1] - a_cyc[1]), 32'd3);
      check("t3 ack gap", 32'(a_cyc[1] - a_cyc[0]), 32'd4);
    end else begin
      check("t3 events", 32'(a_held.size() + w_cyc.size()), 32'd5);
    end

    // start_in during EXEC is ignored
    do_reset();
    clear_mem();
    mem[0] = 16'h7112; mem[1] = 16'h7234; mem[2] = 16'h1312; mem[3] = 16'hF000;
    pulse_start();
    wait_acks(2, 50, "t4 ack2");
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_halt(100, "t4 halt");
    if (a_addr.size() >= 3) check("t4 addr2", 32'(a_addr[2]), 32'd2);
    check("t4 nwr", 32'(w_idx.size()), 32'd3);
    check_write("t4 w2", 2, 3, 16'h0046);

    // PC wraps 0xFF -> 0x00
    do_reset();
    clear_mem();
    mem[255] = 16'h7155;
    pulse_start();
    wait_acks(257, 1500, "t4 wrap acks");
    if (a_addr.size() >= 257) begin
      check("t4 addr ff", 32'(a_addr[255]), 32'hFF);
      check("t4 addr wrap", 32'(a_addr[256]), 32'h00);
    end
    check_write("t4 wrap w0", 0, 1, 16'h0055);

    // Illegal opcode / out-of-range rd
    do_reset();
    clear_mem();
    mem[0] = 16'hA000; mem[1] = 16'h7112; mem[2] = 16'h1912; mem[3] = 16'h7234;
    mem[4] = 16'hF000;
    pulse_start();
    wait_halt(100, "t5 halt");
`ifdef MYCPU_TRAP_EN
    check("t5 trap", 32'(trap_out), 32'd1);
    check("t5 nwr", 32'(w_idx.size()), 32'd0);
    check("t5 nack", 32'(a_addr.size()), 32'd1);
    pulse_start();
    check("t5 trap clr", 32'(trap_out), 32'd0);
    check("t5 restart busy", 32'(busy_out), 32'd1);
`else
    check("t5 trap", 32'(trap_out), 32'd0);
    check("t5 nwr", 32'(w_idx.size()), 32'd2);
    check_write("t5 w0", 0, 1, 16'h0012);
    check_write("t5 w1", 1, 2, 16'h0034);
    check("t5 nack", 32'(a_addr.size()), 32'd5);
`endif

    // Reset asserted in the WB cycle
    do_reset();
    clear_mem();
    mem[0] = 16'h7112; mem[1] = 16'hF000;
    pulse_start();
    begin
      int n = 0;
      while (!bus.rw_out && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6 wb seen", 32'(bus.rw_out), 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("t6 rst");
    check("t6 nwr", 32'(w_idx.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_start();
    wait_acks(1, 20, "t6 ack");
    if (a_addr.size() >= 1) check("t6 addr0", 32'(a_addr[0]), 32'd0);
    wait_halt(50, "t6 halt");
    check_write("t6 w0", 0, 1, 16'h0012);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
